// File: rtl/wavetable_osc_mux_pkg.sv
// Shared waveform codes, round-sequencer state encoding and width helper for the wavetable oscillator.
// Constant-only package; carries no logic.
package wavetable_osc_mux_pkg;

    localparam logic [1:0] WAVE_SINE   = 2'd0;
    localparam logic [1:0] WAVE_SAW    = 2'd1;
    localparam logic [1:0] WAVE_SQUARE = 2'd2;
    localparam logic [1:0] WAVE_TRI    = 2'd3;

    localparam real PI = 3.14159265358979323846;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Channel-index width; a single channel still needs a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wavetable_osc_mux_if.sv
// Control and sample bus of the oscillator: per-channel settings in, channel-serial samples out.
// The master side drives the tick and channel settings; the slave side is the oscillator.
interface wavetable_osc_mux_if
    import wavetable_osc_mux_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int PHASE_W = 24,
    parameter int OUT_W   = 11
);
    localparam int CH_W = clog2_min1(NUM_CH);

    logic                      sample_tick;
    logic [NUM_CH*PHASE_W-1:0] ch_fcw;
    logic [NUM_CH*2-1:0]       ch_wave;
    logic [NUM_CH-1:0]         ch_enable;
    logic [NUM_CH-1:0]         ch_sync;
    logic                      ovr_clr;
    logic                      busy;
    logic                      out_valid;
    logic [CH_W-1:0]           out_ch;
    logic signed [OUT_W-1:0]   out_sample;
    logic                      overrun;

    modport master (
        output sample_tick, ch_fcw, ch_wave, ch_enable, ch_sync, ovr_clr,
        input  busy, out_valid, out_ch, out_sample, overrun
    );

    modport slave (
        input  sample_tick, ch_fcw, ch_wave, ch_enable, ch_sync, ovr_clr,
        output busy, out_valid, out_ch, out_sample, overrun
    );

endinterface

// File: rtl/wavetable_osc_mux_quarter_sine_rom.sv
// Quarter-wave sine table (entries 0..2^(ADDR_W-2) inclusive) with a registered read port.
// Latency 1 cycle; no backpressure, a new address is accepted every cycle.
module wavetable_osc_mux_quarter_sine_rom
    import wavetable_osc_mux_pkg::*;
#(
    parameter int  ADDR_W    = 11,
    parameter int  OUT_W     = 11,
    parameter real AMPLITUDE = 716.0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-2:0]       addr,
    output logic signed [OUT_W-1:0] rd_dat
);
    localparam int Q = 2 ** (ADDR_W - 2);

    logic signed [OUT_W-1:0] rom [Q+1];
    logic signed [OUT_W-1:0] rd_q, rd_d;

    // Same expression as a full-cycle table, so quadrant folding reproduces it exactly.
    for (genvar j = 0; j <= Q; j++) begin : g_rom
        assign rom[j] = OUT_W'($rtoi(AMPLITUDE * $sin(2.0 * PI * real'(j) / real'(2 ** ADDR_W))));
    end

    always_comb begin
        rd_d = rom[addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd_dat = rd_q;

endmodule

// File: rtl/wavetable_osc_mux.sv
// Time-multiplexed N-channel oscillator (sine/saw/square/triangle), one sample per channel per tick.
// Channel k sample 3+k cycles after the tick; no backpressure, a tick while busy is dropped and flagged.
module wavetable_osc_mux
    import wavetable_osc_mux_pkg::*;
#(
    parameter int  NUM_CH    = 4,
    parameter int  PHASE_W   = 24,
    parameter int  ADDR_W    = 11,
    parameter int  OUT_W     = 11,
    parameter real AMPLITUDE = 716.0
) (
    input  logic               clk,
    input  logic               rst,
    wavetable_osc_mux_if.slave bus
);
    localparam int CH_W = clog2_min1(NUM_CH);
    localparam int MSB  = PHASE_W - 1;
    localparam int Q    = 2 ** (ADDR_W - 2);
    localparam logic signed [OUT_W-1:0] SQ_AMP = OUT_W'($rtoi(AMPLITUDE));
    localparam logic [OUT_W-1:0]        HALF   = {1'b1, {(OUT_W-1){1'b0}}};

    state_e             state_q, state_d;
    logic [CH_W-1:0]    ch_cnt_q, ch_cnt_d;
    logic [PHASE_W-1:0] acc_q [NUM_CH];
    logic [PHASE_W-1:0] acc_d [NUM_CH];
    logic               overrun_q, overrun_d;
    logic               slot_vld;
    logic               busy;

    logic [PHASE_W-1:0] s0_fcw, s0_ph;
    logic [1:0]         s0_wave;
    logic               s0_en;
    logic [ADDR_W-1:0]  s0_a;
    logic [ADDR_W-2:0]  rom_addr;
    logic [OUT_W:0]     s0_top;

    logic               s1_vld_q, s1_vld_d;
    logic [CH_W-1:0]    s1_ch_q, s1_ch_d;
    logic [1:0]         s1_wave_q, s1_wave_d;
    logic               s1_en_q, s1_en_d;
    logic               s1_neg_q, s1_neg_d;
    logic [OUT_W:0]     s1_top_q, s1_top_d;
    logic signed [OUT_W-1:0] rom_dat;
    logic [OUT_W-1:0]   saw_v, tri_t, tri_v;
    logic signed [OUT_W-1:0] smp;

    logic               out_vld_q, out_vld_d;
    logic [CH_W-1:0]    out_ch_q, out_ch_d;
    logic signed [OUT_W-1:0] out_sample_q, out_sample_d;

    // Round sequencer: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ch_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ch_cnt_q <= ch_cnt_d;
        end
    end

    // Round sequencer: next state. Busy covers the draining pipeline, so IDLE alone is not enough.
    always_comb begin
        state_d  = state_q;
        ch_cnt_d = ch_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.sample_tick && !busy) begin
                    state_d  = ST_RUN;
                    ch_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (ch_cnt_q == CH_W'(NUM_CH - 1)) begin
                    state_d  = ST_IDLE;
                    ch_cnt_d = '0;
                end else begin
                    ch_cnt_d = ch_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Round sequencer: outputs
    always_comb begin
        slot_vld = (state_q == ST_RUN);
    end

    assign busy = slot_vld || s1_vld_q || out_vld_q;

    always_comb begin
        overrun_d = overrun_q;
        if (bus.ovr_clr) begin
            overrun_d = 1'b0;
        end else if (bus.sample_tick && busy) begin
            overrun_d = 1'b1;
        end
    end

    // S0: phase fetch, sync, accumulator update and quarter-wave address fold.
    always_comb begin
        s0_fcw  = bus.ch_fcw[ch_cnt_q*PHASE_W +: PHASE_W];
        s0_wave = bus.ch_wave[ch_cnt_q*2 +: 2];
        s0_en   = bus.ch_enable[ch_cnt_q];
        s0_ph   = bus.ch_sync[ch_cnt_q] ? '0 : acc_q[ch_cnt_q];
        s0_a    = s0_ph[MSB -: ADDR_W];
        rom_addr = s0_a[ADDR_W-2] ? ((ADDR_W-1)'(Q) - {1'b0, s0_a[ADDR_W-3:0]})
                                  : {1'b0, s0_a[ADDR_W-3:0]};
        for (int k = 0; k < NUM_CH; k++) begin
            acc_d[k] = acc_q[k];
        end
        if (slot_vld && s0_en) begin
            acc_d[ch_cnt_q] = s0_ph + s0_fcw;
        end
    end

    // Top phase bits feeding saw/square/triangle, zero-padded when the phase is narrow.
    if (PHASE_W >= OUT_W + 1) begin : g_top_slice
        assign s0_top = s0_ph[MSB -: OUT_W + 1];
    end else begin : g_top_pad
        assign s0_top = {s0_ph, {(OUT_W + 1 - PHASE_W){1'b0}}};
    end

    wavetable_osc_mux_quarter_sine_rom #(
        .ADDR_W    (ADDR_W),
        .OUT_W     (OUT_W),
        .AMPLITUDE (AMPLITUDE)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .addr   (rom_addr),
        .rd_dat (rom_dat)
    );

    always_comb begin
        s1_vld_d  = slot_vld;
        s1_ch_d   = ch_cnt_q;
        s1_wave_d = s0_wave;
        s1_en_d   = s0_en;
        s1_neg_d  = s0_a[ADDR_W-1];
        s1_top_d  = s0_top;
    end

    // S1: waveform decode against the registered ROM word.
    always_comb begin
        saw_v = {~s1_top_q[OUT_W], s1_top_q[OUT_W-1:1]};
        tri_t = s1_top_q[OUT_W] ? ~s1_top_q[OUT_W-1:0] : s1_top_q[OUT_W-1:0];
        tri_v = tri_t - HALF;
        case (s1_wave_q)
            WAVE_SINE:   smp = s1_neg_q ? -rom_dat : rom_dat;
            WAVE_SAW:    smp = signed'(saw_v);
            WAVE_SQUARE: smp = s1_top_q[OUT_W] ? -SQ_AMP : SQ_AMP;
            WAVE_TRI:    smp = signed'(tri_v);
            default:     smp = '0;
        endcase
        if (!s1_en_q) begin
            smp = '0;
        end
        out_vld_d    = s1_vld_q;
        out_ch_d     = s1_vld_q ? s1_ch_q : out_ch_q;
        out_sample_d = s1_vld_q ? smp : out_sample_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k] <= '0;
            end
            overrun_q    <= 1'b0;
            s1_vld_q     <= 1'b0;
            s1_ch_q      <= '0;
            s1_wave_q    <= '0;
            s1_en_q      <= 1'b0;
            s1_neg_q     <= 1'b0;
            s1_top_q     <= '0;
            out_vld_q    <= 1'b0;
            out_ch_q     <= '0;
            out_sample_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k] <= acc_d[k];
            end
            overrun_q    <= overrun_d;
            s1_vld_q     <= s1_vld_d;
            s1_ch_q      <= s1_ch_d;
            s1_wave_q    <= s1_wave_d;
            s1_en_q      <= s1_en_d;
            s1_neg_q     <= s1_neg_d;
            s1_top_q     <= s1_top_d;
            out_vld_q    <= out_vld_d;
            out_ch_q     <= out_ch_d;
            out_sample_q <= out_sample_d;
        end
    end

    assign bus.busy       = busy;
    assign bus.out_valid  = out_vld_q;
    assign bus.out_ch     = out_ch_q;
    assign bus.out_sample = out_sample_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_wavetable_osc_mux.sv
// Bench for wavetable_osc_mux: fixed vector tables, hand sequences for sync/enable/overrun/reset,
// and randomized rounds scored against an arithmetic reference model.
module tb_wavetable_osc_mux;
    import wavetable_osc_mux_pkg::*;

    localparam int  NUM_CH  = 4;
    localparam int  PHASE_W = 24;
    localparam int  ADDR_W  = 11;
    localparam int  OUT_W   = 11;
    localparam real AMP     = 716.0;
    localparam int  LAST_C  = NUM_CH + 3;

    typedef struct packed {
        logic [PHASE_W-1:0] f;
        logic [7:0]         w;
        int                 e0;
        int                 e1;
        int                 e2;
        int                 e3;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wavetable_osc_mux_if #(.NUM_CH(NUM_CH), .PHASE_W(PHASE_W), .OUT_W(OUT_W)) bus ();

    wavetable_osc_mux #(
        .NUM_CH(NUM_CH), .PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W), .AMPLITUDE(AMP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [PHASE_W-1:0] m_acc [NUM_CH];
    logic               m_ov;
    logic [PHASE_W-1:0] fcw   [NUM_CH];
    logic [1:0]         wave  [NUM_CH];
    logic [NUM_CH-1:0]  en;
    logic [NUM_CH-1:0]  sync;
    int                 got   [NUM_CH];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: sine from the full-cycle formula, other shapes from the phase as a plain number.
    function automatic int ref_sample(input logic [PHASE_W-1:0] p, input logic [1:0] w);
        int a, s, half;
        half = 2 ** (OUT_W - 1);
        a = int'(p >> (PHASE_W - ADDR_W));
        case (w)
            WAVE_SINE:   return $rtoi(AMP * $sin(2.0 * PI * real'(a) / real'(2 ** ADDR_W)));
            WAVE_SAW:    return int'(p >> (PHASE_W - OUT_W)) - half;
            WAVE_SQUARE: return p[PHASE_W-1] ? -$rtoi(AMP) : $rtoi(AMP);
            default: begin
                s = int'(p >> (PHASE_W - 1 - OUT_W)) % (2 * half);
                if (p[PHASE_W-1]) s = 2 * half - 1 - s;
                return s - half;
            end
        endcase
    endfunction

    task automatic apply_inputs();
        for (int k = 0; k < NUM_CH; k++) begin
            bus.ch_fcw[k*PHASE_W +: PHASE_W] = fcw[k];
            bus.ch_wave[k*2 +: 2]            = wave[k];
        end
        bus.ch_enable = en;
        bus.ch_sync   = sync;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) m_acc[k] = '0;
        m_ov = 1'b0;
    endtask

    // Called at a falling edge in an idle cycle (cycle 0); returns at the falling edge of cycle NUM_CH+3.
    task automatic do_round(input int xtick_c, input int clr_c);
        int exp_s [NUM_CH];
        logic [PHASE_W-1:0] p;
        logic t_prev, c_prev, b_prev, v_exp;
        apply_inputs();
        for (int k = 0; k < NUM_CH; k++) begin
            if (en[k]) begin
                p = sync[k] ? '0 : m_acc[k];
                exp_s[k] = ref_sample(p, wave[k]);
                m_acc[k] = p + fcw[k];
            end else begin
                exp_s[k] = 0;
            end
        end
        bus.sample_tick = 1'b1;
        bus.ovr_clr     = 1'b0;
        t_prev = 1'b1; c_prev = 1'b0; b_prev = 1'b0;
        for (int c = 1; c <= LAST_C; c++) begin
            @(negedge clk);
            if (c_prev) m_ov = 1'b0;
            else if (t_prev && b_prev) m_ov = 1'b1;
            b_prev = (c <= NUM_CH + 2);
            v_exp  = (c >= 3) && (c <= NUM_CH + 2);
            chk($sformatf("busy@c%0d", c), int'(bus.busy), int'(b_prev));
            chk($sformatf("overrun@c%0d", c), int'(bus.overrun), int'(m_ov));
            chk($sformatf("out_valid@c%0d", c), int'(bus.out_valid), int'(v_exp));
            if (v_exp && bus.out_valid) begin
                chk($sformatf("out_ch@c%0d", c), int'(bus.out_ch), c - 3);
                got[c-3] = int'(bus.out_sample);
                chk($sformatf("sample[%0d]", c - 3), got[c-3], exp_s[c-3]);
            end
            t_prev = (c == xtick_c);
            c_prev = (c == clr_c);
            bus.sample_tick = t_prev;
            bus.ovr_clr     = c_prev;
        end
        bus.sample_tick = 1'b0;
        bus.ovr_clr     = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_busy", int'(bus.busy), 0);
            chk("idle_valid", int'(bus.out_valid), 0);
            chk("idle_overrun", int'(bus.overrun), int'(m_ov));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_ch"}, int'(bus.out_ch), 0);
        chk({tag, "_sample"}, int'(bus.out_sample), 0);
        chk({tag, "_overrun"}, int'(bus.overrun), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{f: 24'h400000, w: 8'hE4, e0: 0,    e1: -1024, e2: 716,  e3: -1024};
        vecs[1] = '{f: 24'h400000, w: 8'hE4, e0: 716,  e1: -512,  e2: 716,  e3: 0};
        vecs[2] = '{f: 24'h400000, w: 8'hE4, e0: 0,    e1: 0,     e2: -716, e3: 1023};
        vecs[3] = '{f: 24'h400000, w: 8'hE4, e0: -716, e1: 512,   e2: -716, e3: -1};
        vecs[4] = '{f: 24'hFFFFFF, w: 8'h39, e0: -1024, e1: 716,  e2: -1024, e3: 0};
        vecs[5] = '{f: 24'hFFFFFF, w: 8'h39, e0: 1023, e1: -716,  e2: -1024, e3: -2};
        vecs[6] = '{f: 24'hFFFFFF, w: 8'h39, e0: 1023, e1: -716,  e2: -1024, e3: -2};

        rst = 1'b1;
        bus.sample_tick = 1'b0;
        bus.ovr_clr     = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin fcw[k] = '0; wave[k] = WAVE_SINE; end
        en = '1; sync = '0;
        apply_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        check_zero_outputs("por");
        rst = 1'b0;
        idle_cycles(2);

        // Fixed waveform/wrap vectors, back-to-back rounds from phase 0.
        for (int v = 0; v < 7; v++) begin
            int e [NUM_CH];
            e = '{vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3};
            for (int k = 0; k < NUM_CH; k++) begin
                fcw[k]  = vecs[v].f;
                wave[k] = vecs[v].w[k*2 +: 2];
            end
            do_round(0, 0);
            for (int k = 0; k < NUM_CH; k++) chk($sformatf("vec%0d_ch%0d", v, k), got[k], e[k]);
        end

        // Overrun: extra tick in cycle 2, then clear colliding with a fresh overrun tick.
        do_round(2, 0);
        chk("ovr_set", int'(bus.overrun), 1);
        do_round(3, 3);
        chk("ovr_clr_prio", int'(bus.overrun), 0);
        do_round(4, 0);
        do_round(0, 2);
        chk("ovr_clr_plain", int'(bus.overrun), 0);

        // Sync and enable on saw channels, where output shows the phase directly.
        do_reset();
        fcw = '{24'h100000, 24'h180000, 24'h140000, 24'h0E0000};
        wave = '{WAVE_SAW, WAVE_SAW, WAVE_SAW, WAVE_SAW};
        en = '1; sync = '0;
        repeat (3) do_round(0, 0);
        sync = 4'b0100;
        do_round(0, 0);
        chk("sync_ch2_phase0", got[2], -1024);
        sync = '0; en = 4'b1101;
        do_round(0, 0);
        chk("sync_ch2_next", got[2], -864);
        chk("dis_ch1_a", got[1], 0);
        do_round(0, 0);
        chk("dis_ch1_b", got[1], 0);
        en = '1;
        do_round(0, 0);
        chk("reen_ch1", got[1], -256);

        // Full sine sweep on ch0: one table address per round.
        do_reset();
        for (int n = 0; n < 2 ** ADDR_W; n++) begin
            fcw[0] = 24'h002000; wave[0] = WAVE_SINE;
            for (int k = 1; k < NUM_CH; k++) begin
                fcw[k]  = PHASE_W'($urandom);
                wave[k] = 2'($urandom);
            end
            do_round(0, 0);
            if (n == 512)  chk("sine_n512", got[0], 716);
            if (n == 1024) chk("sine_n1024", got[0], 0);
            if (n == 1536) chk("sine_n1536", got[0], -716);
        end

        // Randomized rounds with sync, disable, stray ticks and clears.
        for (int r = 0; r < 300; r++) begin
            int xt, cl;
            for (int k = 0; k < NUM_CH; k++) begin
                fcw[k]   = PHASE_W'($urandom);
                wave[k]  = 2'($urandom);
                en[k]    = ($urandom_range(0, 9) != 0);
                sync[k]  = ($urandom_range(0, 9) == 0);
            end
            xt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, NUM_CH + 2) : 0;
            cl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, NUM_CH + 2) : 0;
            do_round(xt, cl);
        end

        // Reset while ch1 is in the pipeline.
        fcw = '{24'h123456, 24'h0ABCDE, 24'h222222, 24'h345678};
        wave = '{WAVE_SINE, WAVE_SAW, WAVE_SQUARE, WAVE_TRI};
        en = '1; sync = '0;
        apply_inputs();
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_valid", int'(bus.out_valid), 1);
        rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle_cycles(6);
        do_round(0, 0);
        chk("post_rst_ch0", got[0], 0);
        chk("post_rst_ch2", got[2], 716);
        idle_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
